// File: rtl/mm_stream_master_if.sv
// Handshake and word-stream bundle between the operand source,
// the multiplier and the result consumer.
interface mm_stream_master_if #(
  parameter int K = 128,
  parameter int N = 32
);
  logic           op_valid;
  logic           op_ready;
  logic [K*N-1:0] op_x;
  logic [K*N-1:0] op_y;

  logic           mm_start;
  logic [K-1:0]   mm_x;
  logic           mm_x_valid;
  logic [K-1:0]   mm_y;
  logic           mm_y_valid;
  logic [K-1:0]   mm_result;
  logic           mm_valid;

  logic [K*N-1:0] res_data;
  logic           res_valid;
  logic           res_ready;
  logic           res_err;

  modport master (
    input  op_valid, op_x, op_y,
    input  mm_result, mm_valid,
    input  res_ready,
    output op_ready,
    output mm_start,
    output mm_x, mm_x_valid,
    output mm_y, mm_y_valid,
    output res_data, res_valid, res_err
  );

  modport slave (
    output op_valid, op_x, op_y,
    output mm_result, mm_valid,
    output res_ready,
    input  op_ready,
    input  mm_start,
    input  mm_x, mm_x_valid,
    input  mm_y, mm_y_valid,
    input  res_data, res_valid, res_err
  );
endinterface

// File: rtl/mm_stream_master.sv
// Serializes an operand pair into K-bit words for the multiplier
// and reassembles its word stream into one K*N-bit result.
module mm_stream_master #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int TIMEOUT = 4096
) (
  input logic               clk,
  input logic               rst_n,
  mm_stream_master_if.master bus
);

  localparam int W  = K * N;
  localparam int CW = $clog2(N + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] N_ALL  = CW'(N);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic [W-1:0]    res_q;
  logic [CW-1:0]   scnt_q;
  logic [CW-1:0]   rcnt_q;
  logic [TW-1:0]   idle_q;
  logic [K-1:0]    mx_q;
  logic [K-1:0]    my_q;
  logic            op_ready_q;
  logic            start_q;
  logic            val_q;
  logic            res_valid_q;
  logic            res_err_q;

  logic            cap;
  logic            cap_last;
  logic            tmo;

  always_comb begin
    cap = 1'b0;
    if (state_q == SEND || state_q == WAIT ||
        state_q == RECV) begin
      cap = bus.mm_valid && (rcnt_q != N_ALL);
    end
  end

  assign cap_last = cap && (rcnt_q == N_LAST);
  // a word arriving on the final idle cycle still wins
  assign tmo = (TIMEOUT != 0) && !cap &&
               (idle_q == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      scnt_q      <= '0;
      rcnt_q      <= '0;
      idle_q      <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      op_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      val_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (cap) begin
        res_q[rcnt_q*K +: K] <= bus.mm_result;
        rcnt_q <= rcnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (op_ready_q && bus.op_valid) begin
            x_q        <= bus.op_x;
            y_q        <= bus.op_y;
            res_q      <= '0;
            rcnt_q     <= '0;
            res_err_q  <= 1'b0;
            op_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= START;
          end else begin
            op_ready_q <= 1'b1;
          end
        end
        START: begin
          mx_q    <= x_q[K-1:0];
          my_q    <= y_q[K-1:0];
          x_q     <= x_q >> K;
          y_q     <= y_q >> K;
          val_q   <= 1'b1;
          scnt_q  <= CW'(1);
          state_q <= SEND;
        end
        SEND: begin
          if (scnt_q == N_ALL) begin
            val_q   <= 1'b0;
            idle_q  <= '0;
            state_q <= WAIT;
          end else begin
            mx_q   <= x_q[K-1:0];
            my_q   <= y_q[K-1:0];
            x_q    <= x_q >> K;
            y_q    <= y_q >> K;
            scnt_q <= scnt_q + 1'b1;
          end
        end
        WAIT, RECV: begin
          if (rcnt_q == N_ALL || cap_last) begin
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cap) begin
            idle_q  <= '0;
            state_q <= RECV;
          end else if (tmo) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            state_q     <= DONE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_ready   = op_ready_q;
  assign bus.mm_start   = start_q;
  assign bus.mm_x       = mx_q;
  assign bus.mm_y       = my_q;
  assign bus.mm_x_valid = val_q;
  assign bus.mm_y_valid = val_q;
  assign bus.res_data   = res_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_mm_stream_master.sv
// Directed bench for mm_stream_master with a cycle-timestamp
// reference model and a bench-side multiplier responder.
module tb_mm_stream_master;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int TO = 16;
  localparam int W  = K * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mm_stream_master_if #(.K(K), .N(N)) bus ();

  mm_stream_master #(
    .K(K), .N(N), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [K-1:0] xw(input int sel, input int i);
    return {8'(sel), 24'hABCDEF, 32'(i),
            ~32'(i * 3), 32'h5555_0000 ^ 32'(sel)};
  endfunction

  function automatic logic [K-1:0] rword(input int tid,
                                         input int i,
                                         input bit seq);
    if (seq) return 128'(i + 1);
    return {32'hB000_0000 | 32'(tid), 32'(i),
            32'hC0DE_0000 | 32'(i), 32'h1234_5678};
  endfunction

  // responder configuration, set by the main sequence
  int r_lat = 40;
  int r_n   = N;
  bit r_gap = 1'b0;
  bit r_seq = 1'b0;
  int r_tid = 0;
  int cap_cyc = 0;

  initial begin
    int el;
    int i;
    bit ph;
    bit ab;
    bus.mm_valid  = 1'b0;
    bus.mm_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mm_start) begin
        r_tid++;
        el = 0;
        i  = 0;
        ph = 1'b0;
        ab = 1'b0;
        while (i < r_n && !ab) begin
          @(posedge clk);
          #1;
          el++;
          if (el >= r_lat && !(r_gap && ph)) begin
            bus.mm_valid  = 1'b1;
            bus.mm_result = rword(r_tid, i, r_seq);
            i++;
          end else begin
            bus.mm_valid = 1'b0;
          end
          if (el >= r_lat) ph = ~ph;
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          else if (bus.mm_valid) cap_cyc = cyc;
        end
        if (!ab) begin
          @(posedge clk);
          #1;
        end
        bus.mm_valid = 1'b0;
      end
    end
  end

  // reference model: everything keyed on the acceptance cycle
  bit           m_busy  = 1'b0;
  bit           m_err   = 1'b0;
  int           m_tacc  = 0;
  int           m_done  = 0;
  int           m_cnt   = 0;
  int           m_lcap  = -1;
  int           m_since = 0;
  logic [W-1:0] m_x;
  logic [W-1:0] m_y;
  logic [K-1:0] m_res [N];

  always @(negedge clk) begin
    bit e_rdy, e_st, e_v, e_rv;
    int wi, bad, base, wait_c;
    if (!rst_n) begin
      chk({bus.op_ready, bus.mm_start, bus.mm_x_valid,
           bus.mm_y_valid, bus.res_valid, bus.res_err} == 6'b0
          && bus.mm_x == '0 && bus.mm_y == '0
          && bus.res_data == '0,
          "reset_zero",
          {bus.op_ready, bus.mm_start, bus.mm_x_valid,
           bus.mm_y_valid, bus.res_valid, bus.res_err}, 0);
      m_busy  = 1'b0;
      m_err   = 1'b0;
      m_since = cyc + 2;
    end else begin
      wait_c = m_tacc + N + 2;
      e_rdy = !m_busy && cyc >= m_since;
      e_st  = m_busy && cyc == m_tacc + 1;
      e_v   = m_busy && cyc >= m_tacc + 2 && cyc < wait_c;
      e_rv  = m_busy && m_done != 0 && cyc >= m_done;
      chk(bus.op_ready == e_rdy, "op_ready",
          bus.op_ready, e_rdy);
      chk(bus.mm_start == e_st, "mm_start",
          bus.mm_start, e_st);
      chk(bus.mm_x_valid == e_v && bus.mm_y_valid == e_v,
          "mm_valids", {bus.mm_x_valid, bus.mm_y_valid},
          {e_v, e_v});
      if (e_v) begin
        wi = cyc - m_tacc - 2;
        chk(bus.mm_x == m_x[wi*K +: K], "mm_x_word",
            bus.mm_x, m_x[wi*K +: K]);
        chk(bus.mm_y == m_y[wi*K +: K], "mm_y_word",
            bus.mm_y, m_y[wi*K +: K]);
      end
      chk(bus.res_valid == e_rv, "res_valid",
          bus.res_valid, e_rv);
      chk(bus.res_err == m_err, "res_err",
          bus.res_err, m_err);
      if (e_rv) begin
        bad = -1;
        for (int w = 0; w < N; w++)
          if (bad < 0 && bus.res_data[w*K +: K] !== m_res[w])
            bad = w;
        wi = (bad < 0) ? 0 : bad;
        chk(bad < 0, $sformatf("res_data_w%0d", wi),
            bus.res_data[wi*K +: K], m_res[wi]);
      end
      if (e_rdy && bus.op_valid) begin
        m_busy = 1'b1;
        m_tacc = cyc;
        m_done = 0;
        m_cnt  = 0;
        m_lcap = -1;
        m_err  = 1'b0;
        m_x    = bus.op_x;
        m_y    = bus.op_y;
        for (int w = 0; w < N; w++) m_res[w] = '0;
      end else if (m_busy && m_done == 0 &&
                   cyc >= m_tacc + 2) begin
        if (bus.mm_valid) begin
          m_res[m_cnt] = bus.mm_result;
          m_cnt++;
          m_lcap = cyc;
          if (m_cnt == N) m_done = cyc + 1;
        end else if (cyc >= wait_c) begin
          base = (m_lcap + 1 > wait_c) ? m_lcap + 1 : wait_c;
          if (cyc == base + TO - 1) begin
            m_done = cyc + 1;
            m_err  = 1'b1;
          end
        end
      end
      if (e_rv && bus.res_ready) begin
        m_busy  = 1'b0;
        m_since = cyc + 1;
      end
    end
  end

  int st_q[$];
  int hs_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mm_start) st_q.push_back(cyc);
      if (bus.res_valid && bus.res_ready) hs_q.push_back(cyc);
    end
  end

  task automatic wait_rdy(input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.op_ready) return;
    end
    chk(1'b0, {nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rv(input int budget, input string nm,
                         output int rise);
    rise = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        rise = cyc;
        return;
      end
    end
    chk(1'b0, {nm, "_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b1;
    bus.op_x     = x;
    bus.op_y     = y;
    wait_rdy(100, "send");
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic take_result();
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic cfg(input int lat, input int n,
                     input bit gap, input bit seq);
    r_lat = lat;
    r_n   = n;
    r_gap = gap;
    r_seq = seq;
  endtask

  logic [W-1:0] X0, Y0, X1, Y1, X2, Y2;
  int rise;

  initial begin
    for (int i = 0; i < N; i++) begin
      X0[i*K +: K] = xw(1, i);
      Y0[i*K +: K] = xw(9, i);
      X1[i*K +: K] = xw(2, i);
      Y1[i*K +: K] = xw(10, i);
      X2[i*K +: K] = xw(3, i);
      Y2[i*K +: K] = xw(11, i);
    end
    bus.op_valid  = 1'b0;
    bus.op_x      = '0;
    bus.op_y      = '0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(bus.op_ready == 1'b1, "ready_after_reset",
        bus.op_ready, 1);

    // basic stream, transfer tid 1
    cfg(40, N, 1'b0, 1'b0);
    send(X0, Y0);
    wait_rv(200, "basic", rise);
    chk(bus.res_err == 1'b0, "basic_err", bus.res_err, 0);
    chk(bus.res_data[0 +: K] ==
        128'hB0000001_00000000_C0DE0000_12345678,
        "basic_w0", bus.res_data[0 +: K],
        128'hB0000001_00000000_C0DE0000_12345678);
    take_result();

    // gapped results then 50 cycles of backpressure
    cfg(40, N, 1'b1, 1'b1);
    send(X1, Y1);
    wait_rv(300, "gapped", rise);
    chk(bus.res_data[0 +: K] == 128'd1, "gap_w0",
        bus.res_data[0 +: K], 128'd1);
    chk(bus.res_data[17*K +: K] == 128'd18, "gap_w17",
        bus.res_data[17*K +: K], 128'd18);
    repeat (50) @(negedge clk);
    chk(bus.res_data[31*K +: K] == 128'd32, "gap_w31",
        bus.res_data[31*K +: K], 128'd32);
    chk(bus.op_ready == 1'b0, "bp_ready", bus.op_ready, 0);
    take_result();
    @(negedge clk);
    chk(bus.op_ready == 1'b1 && bus.res_valid == 1'b0,
        "idle_after_ready",
        {bus.op_ready, bus.res_valid}, 2'b10);

    // timeout after 5 of 32 words, tid 3
    cfg(40, 5, 1'b0, 1'b0);
    send(X2, Y2);
    wait_rv(300, "timeout", rise);
    // 16 idle cycles after the 5th word, then DONE
    chk(rise - cap_cyc == 17, "timeout_delay",
        128'(rise - cap_cyc), 128'd17);
    chk(bus.res_err == 1'b1, "timeout_err", bus.res_err, 1);
    chk(bus.res_data[4*K +: K] ==
        128'hB0000003_00000004_C0DE0004_12345678,
        "timeout_w4", bus.res_data[4*K +: K],
        128'hB0000003_00000004_C0DE0004_12345678);
    chk(bus.res_data[5*K +: K] == '0 &&
        bus.res_data[31*K +: K] == '0, "timeout_zero",
        bus.res_data[5*K +: K], 0);
    take_result();

    // reset while word 10 is on the stream (tid 4 dropped)
    cfg(40, N, 1'b0, 1'b0);
    send(X0, Y0);
    repeat (11) @(posedge clk);
    #1;
    chk(bus.mm_x_valid && bus.mm_x == xw(1, 10),
        "word10", bus.mm_x, xw(1, 10));
    rst_n = 1'b0;
    #1;
    chk({bus.op_ready, bus.mm_start, bus.mm_x_valid,
         bus.res_valid, bus.res_err} == 5'b0 &&
        bus.res_data == '0, "async_reset",
        {bus.op_ready, bus.mm_x_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(bus.op_ready == 1'b1, "ready_after_midreset",
        bus.op_ready, 1);
    send(X1, Y1);
    wait_rv(200, "post_reset", rise);
    chk(bus.res_data[31*K +: K] ==
        128'hB0000005_0000001F_C0DE001F_12345678,
        "post_reset_w31", bus.res_data[31*K +: K],
        128'hB0000005_0000001F_C0DE001F_12345678);
    take_result();

    // back-to-back pairs with op_valid and res_ready high
    st_q.delete();
    hs_q.delete();
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    bus.op_valid  = 1'b1;
    bus.op_x      = X2;
    bus.op_y      = Y2;
    wait_rdy(100, "b2b_acc1");
    @(posedge clk);
    #1;
    bus.op_x = X0;
    bus.op_y = Y0;
    wait_rdy(300, "b2b_acc2");
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    wait_rv(300, "b2b_res2", rise);
    @(posedge clk);
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    if (st_q.size() >= 2 && hs_q.size() >= 1)
      chk(st_q[1] - hs_q[0] == 2, "b2b_gap",
          128'(st_q[1] - hs_q[0]), 128'd2);
    else
      chk(1'b0, "b2b_events", 128'(st_q.size()), 128'd2);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1);
  end

endmodule
